// File: rtl/writeback_regfile_if.sv
// Bus between the memory stage / decode stage and the Y86-64 write-back register file.
// The master drives the completing instruction and read addresses; the slave returns read data and status.
interface writeback_regfile_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic [3:0]       icode;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic [2:0]       stat_in;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [2:0]       stat_out;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output icode, dstE, dstM, valE, valM, stat_in, srcA, srcB,
    input  valA, valB, stat_out, halted, retired
  );

  modport slave (
    input  icode, dstE, dstM, valE, valM, stat_in, srcA, srcB,
    output valA, valB, stat_out, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: commits valE/valM into 15 program registers, latches status, counts retirements.
// Define WB_BYPASS_EN to forward a same-cycle committing write straight to the decode read ports.
module writeback_regfile #(
  parameter int WIDTH = 64,
  parameter int NREGS = 15,
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  writeback_regfile_if.slave wb
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;
  localparam logic [2:0] STAT_HLT = 3'd4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             commit;
  logic             is_nop;
  logic             retire_inc;

  assign is_nop     = (wb.icode == ICODE_NOP);
  // A nop writes nothing but is still a committed instruction.
  assign retire_inc = commit | (commit & is_nop);

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    regs_d    = regs_q;
    commit    = 1'b0;

    if (state_q == RUN) begin
      case (wb.stat_in)
        STAT_AOK: commit = 1'b1;
        STAT_HLT: begin
          state_d = HALT;
          stat_d  = STAT_HLT;
        end
        STAT_ADR, STAT_INS: begin
          state_d = ERR;
          stat_d  = wb.stat_in;
        end
        default: begin
          state_d = ERR;
          stat_d  = STAT_INS;
        end
      endcase
    end

    // dstM is written second so it wins when both target the same register.
    if (commit) begin
      if (wb.dstE != RNONE) regs_d[wb.dstE] = wb.valE;
      if (wb.dstM != RNONE) regs_d[wb.dstM] = wb.valM;
    end

    if (retire_inc) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = commit & ~rst;
`endif

  always_comb begin
    wb.valA = '0;
    wb.valB = '0;
    if (wb.srcA != RNONE) begin
      wb.valA = regs_q[wb.srcA];
`ifdef WB_BYPASS_EN
      if (bypass_ok && (wb.srcA == wb.dstM))      wb.valA = wb.valM;
      else if (bypass_ok && (wb.srcA == wb.dstE)) wb.valA = wb.valE;
`endif
    end
    if (wb.srcB != RNONE) begin
      wb.valB = regs_q[wb.srcB];
`ifdef WB_BYPASS_EN
      if (bypass_ok && (wb.srcB == wb.dstM))      wb.valB = wb.valM;
      else if (bypass_ok && (wb.srcB == wb.dstE)) wb.valB = wb.valE;
`endif
    end
  end

  assign wb.stat_out = stat_q;
  assign wb.halted   = (state_q != RUN);
  assign wb.retired  = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios then random traffic against an array model.
// Expected read values follow WB_BYPASS_EN the same way the design build does.
module tb_writeback_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0] m_regs [15];
  logic [2:0]  m_stat;
  logic        m_halted;
  logic [31:0] m_retired;

  writeback_regfile_if #(.WIDTH(64), .CNT_W(32)) bus ();

  writeback_regfile #(.WIDTH(64), .NREGS(15), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] expRead(input logic [3:0] src);
    logic commits;
    commits = !rst && !m_halted && (bus.stat_in == 3'd1);
    if (src == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
    if (commits && src == bus.dstM) return bus.valM;
    if (commits && src == bus.dstE) return bus.valE;
`else
    if (commits) begin end
`endif
    return m_regs[src];
  endfunction

  // Architectural meaning of one clock edge with the current inputs.
  task automatic modelStep();
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_stat    = 3'd1;
      m_halted  = 1'b0;
      m_retired = 32'd0;
    end else if (!m_halted) begin
      if (bus.stat_in == 3'd1) begin
        if (bus.dstE != 4'hF) m_regs[bus.dstE] = bus.valE;
        if (bus.dstM != 4'hF) m_regs[bus.dstM] = bus.valM;
        m_retired = m_retired + 32'd1;
      end else begin
        m_halted = 1'b1;
        if (bus.stat_in inside {3'd2, 3'd3, 3'd4}) m_stat = bus.stat_in;
        else m_stat = 3'd3;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] ic, input logic [3:0] de,
                               input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                               input logic [2:0] st, input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    rst         = r;
    bus.icode   = ic;
    bus.dstE    = de;
    bus.dstM    = dm;
    bus.valE    = ve;
    bus.valM    = vm;
    bus.stat_in = st;
    bus.srcA    = sa;
    bus.srcB    = sb;
    #1;
    checkOutput("valA", bus.valA, expRead(sa));
    checkOutput("valB", bus.valB, expRead(sb));
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("stat_out", 64'(bus.stat_out), 64'(m_stat));
    checkOutput("halted", 64'(bus.halted), 64'(m_halted));
    checkOutput("retired", 64'(bus.retired), 64'(m_retired));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.icode = 4'h1; bus.dstE = 4'hF; bus.dstM = 4'hF;
    bus.valE = '0; bus.valM = '0; bus.stat_in = 3'd1;
    bus.srcA = 4'hF; bus.srcB = 4'hF;
    foreach (m_regs[i]) m_regs[i] = 64'd0;
    m_stat = 3'd1; m_halted = 1'b0; m_retired = 32'd0;
    repeat (2) @(posedge clk);

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd0, 4'd14);
    applyStimulus(1'b0, 4'h6, 4'd3, 4'hF, 64'h1234, 64'd0, 3'd1, 4'd3, 4'hF);
    applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd3, 4'hF);
    checkOutput("reg3_after_write", bus.valA, 64'h1234);
    applyStimulus(1'b0, 4'hB, 4'd4, 4'd4, 64'd5, 64'd9, 3'd1, 4'hF, 4'hF);
    applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd4, 4'hF);
    checkOutput("reg4_valM_wins", bus.valA, 64'd9);
    applyStimulus(1'b0, 4'h5, 4'hF, 4'd6, 64'd0, 64'hAA, 3'd1, 4'hF, 4'd6);
    applyStimulus(1'b0, 4'h0, 4'd2, 4'hF, 64'd7, 64'd0, 3'd4, 4'd2, 4'hF);
    applyStimulus(1'b0, 4'h6, 4'd2, 4'd5, 64'd11, 64'd12, 3'd1, 4'd2, 4'd5);
    applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd2, 4'd6);
    applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd4, 4'd3);
    applyStimulus(1'b0, 4'h5, 4'd1, 4'hF, 64'd3, 64'd0, 3'd2, 4'd1, 4'hF);
    applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'd6, 4'd9);
    applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd7, 4'hF, 4'hF);
    applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 4'hF, 4'hF);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [2:0]  st;
      logic [3:0]  de, dm;
      r  = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 94) ? 3'd1 : 3'($urandom_range(0, 7));
      de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) dm = de;
      applyStimulus(r, 4'($urandom_range(0, 11)), de, dm,
                    {$urandom, $urandom}, {$urandom, $urandom}, st,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
